// File: rtl/operand_issue.sv
// Decode-to-execute issue stage: RAW hazard resolution, operand bundle register and stall counter.
// Define OPERAND_FWD_EN to forward from EX/MEM and stall only on load-use; undefined stalls on every RAW hit.
module operand_issue #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_opcode,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic [RW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_dst,
    input  logic [DW-1:0] mem_result,
    input  logic          flush,
    output logic          ex_valid,
    output logic [3:0]    ex_opcode,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_dst,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          stall,
    output logic [15:0]   stall_count
);

    logic [RW-1:0] src    [2];
    logic          use_k  [2];
    logic [DW-1:0] rf     [2];
    logic [DW-1:0] op_sel [2];
    logic [1:0]    exhit;
    logic [1:0]    memhit;

    assign src[0]   = id_src1;
    assign src[1]   = id_src2;
    assign use_k[0] = id_use1;
    assign use_k[1] = id_use2;
    assign rf[0]    = rf_data1;
    assign rf[1]    = rf_data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign exhit[gi]  = id_valid & use_k[gi] & ex_valid & ex_regwrite & (ex_dst == src[gi]);
            assign memhit[gi] = id_valid & use_k[gi] & mem_regwrite & (mem_dst == src[gi]);
`ifdef OPERAND_FWD_EN
            // The younger writer (EX) holds the newest value, so it takes priority over MEM.
            assign op_sel[gi] = exhit[gi] ? ex_result : (memhit[gi] ? mem_result : rf[gi]);
`else
            assign op_sel[gi] = rf[gi];
`endif
        end
    endgenerate

`ifdef OPERAND_FWD_EN
    // Only a load in EX has no result yet; everything else is covered by forwarding.
    assign stall = ~flush & (|exhit) & ex_memread;
`else
    assign stall = ~flush & ((|exhit) | (|memhit));
    logic unused_fwd;
    assign unused_fwd = ^{ex_result, mem_result};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_dst      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_dst      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (stall) begin
            // Bubble: the data fields keep their old values, only the control bits are killed.
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_opcode   <= id_opcode;
            ex_op1      <= op_sel[0];
            ex_op2      <= op_sel[1];
            ex_imm      <= id_imm;
            ex_dst      <= id_dst;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: doc/operand_issue.md
# operand_issue

Decode-to-execute issue stage of the 16-bit pipeline. It sits directly downstream of the 16-entry register file. It takes the two read-port values for the instruction in decode, resolves RAW hazards against in-flight writers by forwarding or stalling, and registers a complete operand bundle into the execute stage. It also drives the pipeline stall and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register-id width (16 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_opcode  in  4  decoded opcode
- id_src1, id_src2  in  RW  source register ids; also drive the register file SrcReg1/SrcReg2
- id_use1, id_use2  in  1  the instruction actually reads src1/src2
- id_dst  in  RW  destination register id
- id_regwrite, id_memread  in  1  instruction writes a register / is a load
- id_imm  in  DW  sign-extended immediate
- rf_data1, rf_data2  in  DW  register file SrcData1/SrcData2; these already bypass a same-cycle writeback
- ex_result  in  DW  combinational execute-stage result of the instruction currently held in this stage
- mem_regwrite  in  1  memory stage will write a register
- mem_dst  in  RW  memory-stage destination id
- mem_result  in  DW  memory-stage result
- flush  in  1  kill the decode instruction and the held execute instruction
- ex_valid, ex_opcode, ex_op1, ex_op2, ex_imm, ex_dst, ex_regwrite, ex_memread  out  —  registered bundle to execute; widths match the id_* inputs
- stall  out  1  combinational; freeze fetch/decode this cycle
- stall_count  out  16  saturating count of stall cycles

## Operation
Hazard terms (combinational):
- `exhit_k = id_valid & id_use_k & ex_valid & ex_regwrite & (ex_dst == id_src_k)`
- `memhit_k = id_valid & id_use_k & mem_regwrite & (mem_dst == id_src_k)`
- `load_use = exhit_1&ex_memread | exhit_2&ex_memread`
- `stall = ~flush & load_use`

Operand select for k = 1, 2, in priority order:
- exhit_k: use ex_result
- memhit_k: use mem_result
- otherwise: use rf_data_k

Register update each clock, in priority order:
- flush: ex_valid←0; all other outputs←0.
- stall: bubble. ex_valid←0, ex_regwrite←0, ex_memread←0. Decode holds its instruction, and it re-issues next cycle with mem forwarding.
- otherwise: the bundle is loaded from the id_* inputs and the selected operands; ex_valid←id_valid.

Control rules:
- Register 0 is an ordinary register; there is no zero special case.
- stall_count increments by one on every cycle with stall=1 and saturates at 16'hFFFF.
- stall_count does not wrap, and flush does not clear it.

## Timing
- Operand bundle latency is one cycle: decode in cycle N appears on ex_* at N+1.
- stall is valid in the same cycle as the hazard.
- A load-use hazard costs exactly one bubble cycle. On the following cycle the load is in the memory stage and is forwarded from mem_result.
- Simultaneous flush and stall: flush wins. stall=0, no bubble is counted, and the bundle is cleared.
- Reset (asynchronous assert, release synchronized by the system):
  - all ex_* outputs and stall_count are 0
  - stall is 0, because ex_valid=0
- Reset mid-stall drops the pending bubble and the count.

## Configuration
- `OPERAND_FWD_EN` defined:
  - forwarding as described
  - stall only on load-use
- `OPERAND_FWD_EN` undefined:
  - no forwarding; operands always come from rf_data_k
  - stall = ~flush & (exhit_1 | exhit_2 | memhit_1 | memhit_2), regardless of ex_memread
  - a dependent instruction immediately behind a writer stalls 2 cycles, and behind a writer one slot ahead stalls 1 cycle
  - stall_count behaviour is unchanged

## Test plan
- **Reset:** assert rst=0 mid-stream → all ex_* = 0, stall=0, stall_count=0 immediately; no output change on clk until release.
- **EX forwarding (with OPERAND_FWD_EN):**
  - stimulus: ADD writing R3 is held; next decode reads R3 with rf_data1=16'h0000 and ex_result=16'h1234
  - required: ex_op1=16'h1234 next cycle, stall=0
  - with both EX and MEM writing R3, EX wins
- **Load-use:** held load writing R5; decode reads R5 → stall=1 for one cycle and ex_valid=0 next cycle. Then mem_result=16'hBEEF is forwarded, ex_op2=16'hBEEF, and stall_count increments by 1.
- **Flush with hazard:** flush=1 during a load-use → stall=0, ex_valid=0 next cycle, stall_count unchanged.
- **No forwarding (OPERAND_FWD_EN undefined):**
  - back-to-back ADD R2 → SUB using R2 gives exactly 2 stall cycles
  - the SUB then issues with ex_op1 = rf_data1
  - stall_count=2
- **Saturation:** force 65540 consecutive load-use stall cycles → stall_count holds 16'hFFFF.
